spi_byte_receiver: RTL
======================

# spi_byte_receiver

Receiving end of the team's serial byte link. Samples the externally supplied serial clock, enable and data lines with the local system clock and reassembles LSB-first bytes. Presents each completed byte on a valid/ready handshake toward the downstream consumer (decryption / hash-table input). Reports aborted frames and overruns.

## Interface
- DATA_W, 8, bits per frame; the bit counter is $clog2(DATA_W)+1 bits wide
- SYNC_STAGES, 2, flip-flop stages on each serial input (minimum 2)
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  asynchronous, active-high reset
- sclk_in  input  1  serial clock from transmitter; data sampled on its rising edge
- en_in  input  1  frame enable, active-low; low for the whole frame
- data_in  input  1  serial data, LSB first
- rx_data  output  DATA_W  received byte; stable while rx_valid=1
- rx_valid  output  1  byte available; held until accepted
- rx_ready  input  1  consumer accepts rx_data when rx_valid&&rx_ready
- busy  output  1  frame in progress (state SHIFT or WAIT_END)
- frame_err  output  1  one-cycle pulse: frame aborted or over-long
- overrun  output  1  one-cycle pulse: completed byte dropped, output still full

## Operation
- sclk_in, en_in and data_in each pass through SYNC_STAGES flops. A rising edge is detected when the last sync stage is 1 and a 1-cycle-delayed copy is 0. The data bit is taken from the last sync stage in the same cycle.
- State IDLE: shift register and bit count are 0. Synchronized en_in=0 -> SHIFT. sclk edges while en_in=1 are ignored.
- State SHIFT: each detected sclk rise does sr <= {bit, sr[DATA_W-1:1]} and count+1.
  - When count reaches DATA_W, the byte completes -> WAIT_END.
  - en_in=1 with count 1..DATA_W-1: frame_err pulse, discard, -> IDLE.
  - en_in=1 with count 0: silent return to IDLE, no error.
- State WAIT_END: en_in=1 -> IDLE. Any sclk rise here: frame_err pulse, remain in WAIT_END. No further data is captured until en_in goes high.
- Byte completion, in the cycle after the DATA_W-th edge is detected:
  - If rx_valid=0, or rx_valid&&rx_ready in that same cycle: rx_data <= sr and rx_valid=1.
  - Otherwise: overrun pulse. The new byte is dropped and the old rx_data is kept.
- Acceptance: rx_valid&&rx_ready with no simultaneous completion -> rx_valid=0 next cycle. rx_data keeps its last value.
- Reset, any time including mid-frame: state IDLE, count 0, sr 0, sync flops 1 for en_in and 0 for sclk_in/data_in. The partial frame is lost with no error pulse.
  - Output reset values: rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
- After reset release, the receiver does not enter SHIFT until it has seen synchronized en_in=1 at least once. This prevents a false start if en_in is already low.

## Timing
- Input requirement: sclk_in high and low each ≥ 2 clk periods. en_in falls ≥ 2 clk before the first sclk rise and rises ≥ 2 clk after the last sclk rise.
- Edge-to-detect latency: SYNC_STAGES+1 clk from an sclk_in transition to the internal strobe (3 at default).
- Last sclk rise to rx_valid=1: SYNC_STAGES+2 clk (4 at default).
- busy rises SYNC_STAGES+1 clk after en_in falls. It falls the same amount after en_in rises, or on an abort.
- frame_err and overrun are exactly 1 clk wide and registered. They may assert in the same cycle as each other.
- Back-to-back frames need no idle gap beyond the en_in high time needed to reach IDLE (≥ 2 clk).

## Test plan
- Frame 8'hA5 sent LSB first (1,0,1,0,0,1,0,1), rx_ready=1 -> rx_data=8'hA5 with a one-cycle rx_valid pulse 4 clk after the 8th sclk rise; busy covers the frame; no error pulses.
- Two frames 8'h3C then 8'hC3 with rx_ready=0 -> rx_data holds 8'h3C, overrun pulses once; asserting rx_ready afterwards returns rx_data=8'h3C and rx_valid=0.
- Frame 8'h11 completes with rx_ready=1 in the same cycle as the pending 8'h22 is accepted -> rx_valid stays 1, rx_data=8'h11, no overrun.
- en_in raised after 5 bits -> frame_err one-cycle pulse, rx_valid stays 0; the next full frame 8'h7E is received correctly.
- 9 sclk rises within one frame 8'hFF -> rx_data=8'hFF and exactly one frame_err pulse on the 9th edge.
- rst asserted asynchronously after 4 bits -> all outputs 0 immediately; with en_in held low through reset release, no byte is captured until en_in has gone high and low again; then 8'h5A is received.

Source files
------------

// File: rtl/spi_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_receiver
// Description : Receiving end of the serial byte link. Oversamples the
//               transmitter's serial clock, frame enable and data lines with
//               the local clock, reassembles LSB-first frames of DATA_W bits
//               and offers each completed byte on a valid/ready handshake.
//               Aborted / over-long frames pulse frame_err; a byte completed
//               while the output is still full is dropped and pulses overrun.
// Ports       : clk, rst            - system clock, async active-high reset
//               sclk_in, en_in,     - raw serial clock, active-low frame
//               data_in               enable, serial data (LSB first)
//               rx_data, rx_valid,  - output byte handshake toward consumer
//               rx_ready
//               busy                - frame in progress
//               frame_err, overrun  - single-cycle status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_receiver #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              en_in,
    input  logic              data_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int c_CNT_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_SHIFT    = 2'd1;
    localparam logic [1:0] c_WAIT_END = 2'd2;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_en_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    // Marks when the last sync stage holds a genuinely sampled value rather
    // than its reset preset, so the preset 1 on en_in cannot arm the receiver.
    logic [SYNC_STAGES-1:0] r_settle;
    logic                   r_sclk_d;
    logic                   r_armed;
    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_count;
    logic [DATA_W-1:0]      r_sr;
    logic                   r_done;

    logic w_sclk_rise;
    logic w_en;
    logic w_bit;
    logic w_settled;

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
    assign w_en        = r_en_sync[SYNC_STAGES-1];
    assign w_bit       = r_data_sync[SYNC_STAGES-1];
    assign w_settled   = r_settle[SYNC_STAGES-1];
    assign busy        = (r_state == c_SHIFT) || (r_state == c_WAIT_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_en_sync   <= '1;
            r_data_sync <= '0;
            r_settle    <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_en_sync   <= {r_en_sync[SYNC_STAGES-2:0], en_in};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data_in};
            r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_count   <= '0;
            r_sr      <= '0;
            r_armed   <= 1'b0;
            r_done    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            frame_err <= 1'b0;
            if (w_settled && w_en) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    r_sr    <= '0;
                    r_count <= '0;
                    if (w_settled && r_armed && !w_en) begin
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (w_en) begin
                        // A frame closed before any bit is just an empty frame.
                        if (r_count != '0) begin
                            frame_err <= 1'b1;
                        end
                        r_state <= c_IDLE;
                        r_sr    <= '0;
                        r_count <= '0;
                    end else if (w_sclk_rise) begin
                        r_sr    <= {w_bit, r_sr[DATA_W-1:1]};
                        r_count <= r_count + c_CNT_W'(1);
                        if (r_count == c_CNT_W'(DATA_W - 1)) begin
                            r_state <= c_WAIT_END;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_WAIT_END: begin
                    // The completed byte stays in r_sr until the frame closes;
                    // extra clock edges are flagged but never shifted in.
                    if (w_en) begin
                        r_state <= c_IDLE;
                        r_sr    <= '0;
                        r_count <= '0;
                    end else if (w_sclk_rise) begin
                        frame_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (r_done) begin
                // Slot is free if empty or being drained in this same cycle.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= r_sr;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
